rv_pipe_ctrl: RTL

- Pipeline sequencing controller for the fetch → decode → ALU1 front end.
- Evaluates the instruction currently held in the ALU1 stage and handles four events: control-flow mispredicts, traps, memory back-pressure and load-use hazards.
- Drives registered redirect, flush and stall controls back into the fetch, decode and ALU1 registers.
- Keeps a saturating redirect counter for performance monitoring.

---
 rtl/rv_pipe_ctrl_if.sv | 51 +++++
 rtl/rv_pipe_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/rv_pipe_ctrl_if.sv
// Front-end sequencing bundle between the fetch/decode/ALU1 pipeline and its controller.
// Latency: none; this is a wire bundle only.
// Backpressure: none; stall and flush controls travel back to the pipeline on this bundle.
interface rv_pipe_ctrl_if #(
    parameter int IADDR_SPACE_BITS = 32
);
    // ALU1-stage instruction and its resolved control flow
    logic                        i_alu_valid;
    logic [IADDR_SPACE_BITS-1:0] i_pc;
    logic [IADDR_SPACE_BITS-1:0] i_pc_next;
    logic [IADDR_SPACE_BITS-1:0] i_pc_target;
    logic                        i_inst_jal_jalr;
    logic                        i_inst_branch;
    logic                        i_branch_taken;
    logic                        i_to_trap;
    logic [IADDR_SPACE_BITS-1:0] i_trap_vec;
    // load-use hazard inputs
    logic                        i_alu_load;
    logic [4:0]                  i_alu_rd;
    logic [4:0]                  i_dec_rs1;
    logic [4:0]                  i_dec_rs2;
    // memory back-pressure
    logic                        i_mem_busy;
    // controls back into the pipeline
    logic                        o_redirect;
    logic [IADDR_SPACE_BITS-1:0] o_redirect_pc;
    logic                        o_flush;
    logic                        o_stall_front;
    logic                        o_bubble_alu;
    logic                        o_stall_all;
    logic [1:0]                  o_state;
    logic [15:0]                 o_redirect_cnt;

    // pipeline side: presents the ALU1 instruction, obeys the controls
    modport master (
        output i_alu_valid, i_pc, i_pc_next, i_pc_target, i_inst_jal_jalr,
               i_inst_branch, i_branch_taken, i_to_trap, i_trap_vec,
               i_alu_load, i_alu_rd, i_dec_rs1, i_dec_rs2, i_mem_busy,
        input  o_redirect, o_redirect_pc, o_flush, o_stall_front,
               o_bubble_alu, o_stall_all, o_state, o_redirect_cnt
    );

    // controller side
    modport slave (
        input  i_alu_valid, i_pc, i_pc_next, i_pc_target, i_inst_jal_jalr,
               i_inst_branch, i_branch_taken, i_to_trap, i_trap_vec,
               i_alu_load, i_alu_rd, i_dec_rs1, i_dec_rs2, i_mem_busy,
        output o_redirect, o_redirect_pc, o_flush, o_stall_front,
               o_bubble_alu, o_stall_all, o_state, o_redirect_cnt
    );
endinterface

// File: rtl/rv_pipe_ctrl.sv
// Front-end sequencer: redirect/flush on trap or mispredict, stall on load-use, freeze on memory busy.
// Latency: redirect/flush/state registered one cycle after the ALU1 event; stalls and bubble are combinational.
// Backpressure: i_mem_busy freezes everything (o_stall_all) and holds any flush countdown.
module rv_pipe_ctrl #(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int FLUSH_CYCLES     = 2
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    rv_pipe_ctrl_if.slave bus
);
    typedef logic [IADDR_SPACE_BITS-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    // flush countdown starts one below the length because the redirect cycle itself counts
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [3:0]  flush_cnt;
    logic        redirect_q;
    addr_t       redirect_pc_q;
    logic        flush_q;
    logic [15:0] redirect_cnt;

    addr_t next_pc;
    logic  eval_alu;
    logic  ev_trap;
    logic  ev_mispredict;
    logic  ev_hazard;
    logic  redirect_req;

    // resolve the architectural next PC and decode ALU1 events (only meaningful in RUN, not frozen)
    always_comb begin
        next_pc = bus.i_pc + addr_t'(4);
        if (bus.i_inst_jal_jalr || (bus.i_inst_branch && bus.i_branch_taken)) begin
            next_pc = bus.i_pc_target;
        end
        eval_alu      = (state == ST_RUN) && !bus.i_mem_busy && bus.i_alu_valid;
        ev_trap       = eval_alu && bus.i_to_trap;
        ev_mispredict = eval_alu && (next_pc != bus.i_pc_next);
        ev_hazard     = eval_alu && bus.i_alu_load && (bus.i_alu_rd != 5'd0) &&
                        ((bus.i_alu_rd == bus.i_dec_rs1) || (bus.i_alu_rd == bus.i_dec_rs2));
        redirect_req  = ev_trap || ev_mispredict;
    end

    // memory busy freezes the whole front end in every state
    assign bus.o_stall_all    = bus.i_mem_busy;
    // a redirect already kills the younger instruction, so the hazard stall only matters alone
    assign bus.o_stall_front  = ev_hazard && !redirect_req;
    assign bus.o_bubble_alu   = ev_hazard && !redirect_req;
    assign bus.o_redirect     = redirect_q;
    assign bus.o_redirect_pc  = redirect_pc_q;
    assign bus.o_flush        = flush_q;
    assign bus.o_state        = state;
    assign bus.o_redirect_cnt = redirect_cnt;

    // sequencing FSM with its registered redirect, flush and counter outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ST_RUN;
            flush_cnt     <= 4'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            redirect_cnt  <= 16'd0;
        end else begin
            redirect_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (bus.i_mem_busy) begin
                        state <= ST_MEMWAIT;
                    end else if (redirect_req) begin
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= ev_trap ? bus.i_trap_vec : next_pc;
                        flush_q       <= 1'b1;
                        flush_cnt     <= FLUSH_LOAD;
                        state         <= ST_FLUSH;
                        if (redirect_cnt != 16'hFFFF) begin
                            redirect_cnt <= redirect_cnt + 16'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!bus.i_mem_busy) begin
                        if (flush_cnt == 4'd0) begin
                            flush_q <= 1'b0;
                            state   <= ST_RUN;
                        end else begin
                            flush_cnt <= flush_cnt - 4'd1;
                        end
                    end
                end
                ST_MEMWAIT: begin
                    if (!bus.i_mem_busy) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    flush_q <= 1'b0;
                    state   <= ST_RUN;
                end
            endcase
        end
    end
endmodule
